// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and defaults for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } sub_state_t;

    localparam int DEFAULT_N = 8;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational full subtractor cell
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor, LSB first, start/done handshake
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic         ovf,
`endif
    output logic         borrow
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    sub_state_t    state;
    logic [N-1:0]  ra;
    logic [N-1:0]  rb;
    logic [N-1:0]  res;
    logic [N-1:0]  res_next;
    logic [CW-1:0] cnt;
    logic          bin;
    logic          cell_d;
    logic          cell_bout;

    full_subtractor u_cell (
        .a    (ra[cnt]),
        .b    (rb[cnt]),
        .bin  (bin),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Working result with the current bit merged in, so the final copy to diff
    // already contains the MSB computed on the last CALC edge.
    always_comb begin
        res_next      = res;
        res_next[cnt] = cell_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            res    <= '0;
            cnt    <= '0;
            bin    <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        res   <= '0;
                        cnt   <= '0;
                        bin   <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    res <= res_next;
                    bin <= cell_bout;
                    if (cnt == LAST) begin
                        diff   <= res_next;
                        borrow <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                        ovf    <= (ra[N-1] ^ rb[N-1]) & (res_next[N-1] ^ ra[N-1]);
`endif
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor with randomized operands
module tb_serial_subtractor;

    localparam int N   = 8;
    localparam int MOD = 1 << N;

    typedef struct {
        logic [N-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [N-1:0] last_diff;

    serial_subtractor #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf    (ovf),
`endif
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int av, input int bv);
        exp_t e;
        int   sa, sb, sr;
        e.diff   = N'((av - bv + MOD) % MOD);
        e.borrow = (av < bv);
        sa = (av >= MOD / 2) ? av - MOD : av;
        sb = (bv >= MOD / 2) ? bv - MOD : bv;
        sr = sa - sb;
        e.ovf = (sr < -(MOD / 2)) || (sr > (MOD / 2 - 1));
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("diff", int'(diff), int'(e.diff));
                check("borrow", int'(borrow), int'(e.borrow));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", int'(ovf), int'(e.ovf));
`endif
            end
        end
    end

    task automatic run_op(input int av, input int bv);
        int bc, dpos, w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (busy && w < 4 * N) begin
            @(negedge clk);
            w++;
        end
        if (busy) check("idle_wait_timeout", 1, 0);
        start = 1'b1;
        a     = N'(av);
        b     = N'(bv);
        @(posedge clk);
        e = model(av, bv);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        bc    = busy ? 1 : 0;
        dpos  = done ? 0 : -1;
        check("diff_hold_calc", int'(diff), int'(last_diff));
        for (int k = 1; k <= N + 1; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done && dpos < 0) dpos = k;
            if (k < N) check("diff_hold_calc", int'(diff), int'(last_diff));
        end
        check("busy_cycles", bc, N + 1);
        check("done_latency", dpos, N);
        last_diff = e.diff;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int ndone, last_done, w;
        logic prev_busy;
        int dir_a[7] = '{100, 37, 0, 0, 255, 255, 0};
        int dir_b[7] = '{37, 100, 1, 0, 255, 0, 255};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        last_diff = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_diff", int'(diff), 0);
        check("reset_borrow", int'(borrow), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_op(dir_a[i], dir_b[i]);
`ifdef SERIAL_SUB_OVF_EN
        run_op(127, 255);
        run_op(128, 1);
        run_op(50, 20);
`endif

        // start held high; operands scrambled whenever the unit is busy
        @(negedge clk);
        start = 1'b1;
        a = N'(5);
        b = N'(3);
        prev_busy = busy;
        ndone = 0;
        last_done = -1;
        for (int cyc = 0; cyc < 5 * (N + 2); cyc++) begin
            @(posedge clk);
            #1;
            if (busy && !prev_busy) exp_q.push_back(model(5, 3));
            prev_busy = busy;
            if (done) begin
                if (last_done >= 0) begin
                    checks++;
                    if (cyc - last_done < N + 1 || cyc - last_done > N + 2) begin
                        errors++;
                        $display("FAIL done_gap: got %0d expected %0d..%0d", cyc - last_done, N + 1, N + 2);
                    end
                end
                last_done = cyc;
                ndone++;
            end
            if (busy) begin
                a = N'($urandom);
                b = N'($urandom);
            end else begin
                a = N'(5);
                b = N'(3);
            end
        end
        start = 1'b0;
        repeat (2 * N + 4) @(negedge clk);
        checks++;
        if (ndone < 4) begin
            errors++;
            $display("FAIL continuous_done_count: got %0d expected at least 4", ndone);
        end
        check("continuous_queue_drained", exp_q.size(), 0);
        last_diff = N'(2);

        // reset in the middle of an operation
        @(negedge clk);
        start = 1'b1;
        a = N'(200);
        b = N'(1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        check("midreset_diff", int'(diff), 0);
        check("midreset_borrow", int'(borrow), 0);
`ifdef SERIAL_SUB_OVF_EN
        check("midreset_ovf", int'(ovf), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        w = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (done) w++;
        end
        check("midreset_no_done", w, 0);
        last_diff = '0;
        run_op(9, 4);

        for (int i = 0; i < 1500; i++) run_op(int'($urandom_range(MOD - 1, 0)), int'($urandom_range(MOD - 1, 0)));

        repeat (2) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
